store_commit_queue: RTL
=======================

Name: store_commit_queue

Overview:
- In-order store queue that buffers S-type instructions from dispatch until ROB retirement.
- Captures resolved address and data from FU mem.
- Drains retired stores one per cycle to data memory through the store_wb / lsq write port. It is the initiator of the store writes that the data memory consumes.
- Sits between dispatch/FU mem/ROB and data memory. Uncommitted stores are discarded on flush.

Parameters:
- DEPTH, 8, number of store entries (power of two).
- TAG_W, 5, ROB tag width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  dispatch allocates a store.
- alloc_rob_tag  in  TAG_W  ROB index of allocated store.
- alloc_sh  in  1  0 = sw, 1 = sh.
- alloc_ready  out  1  queue can accept an allocation.
- agu_valid  in  1  FU mem resolved a store.
- agu_rob_tag  in  TAG_W  tag of resolved store.
- agu_addr  in  32  byte address.
- agu_data  in  32  ps2 source data.
- retire_valid  in  1  ROB retires a store this cycle.
- retire_rob_tag  in  TAG_W  tag of retiring store.
- flush  in  1  mispredict; discard all uncommitted entries.
- store_wb  out  1  one-cycle write strobe to data memory.
- wb_addr  out  32  write address (lsq.addr).
- wb_data  out  32  write data (lsq.ps2_data).
- wb_sw_sh  out  1  lsq.sw_sh_signal.
- wb_rob_tag  out  TAG_W  lsq.rob_tag.
- sq_count  out  $clog2(DEPTH)+1  occupied entries.
- retire_err  out  1  sticky protocol error flag.

Behaviour:
- Storage
  - Circular buffer with head (drain), cptr (oldest uncommitted) and tail (alloc) pointers, each $clog2(DEPTH)+1 bits with wrap bit.
  - Per entry: valid, rob_tag, sh, addr, data, addr_valid, committed.
- Reset (reset low, async)
  - All pointers, entry valid/committed/addr_valid = 0.
  - store_wb = 0, wb_* = 0, sq_count = 0, retire_err = 0, alloc_ready = 1.
- Allocation
  - alloc_ready = (sq_count != DEPTH), combinational from registered state.
  - alloc_valid && alloc_ready writes the entry at tail (addr_valid = 0, committed = 0) and increments tail.
  - alloc_valid while full is dropped and sets retire_err.
  - A drain in the same cycle does not free space for that cycle's allocation.
- AGU update
  - agu_valid CAM-matches valid, uncommitted entries on rob_tag.
  - On a match: write addr/data and set addr_valid.
  - No match is ignored. A repeat match overwrites.
  - An update to an entry allocated in the same cycle is not visible.
- Retire
  - If retire_valid and entry[cptr] is valid, uncommitted, and has rob_tag == retire_rob_tag: set committed and increment cptr.
  - Otherwise set retire_err (sticky until reset) and make no state change.
  - At most one retire per cycle.
- Drain
  - If entry[head] is valid, committed and addr_valid:
    - Next cycle store_wb = 1 with wb_addr/wb_data/wb_sw_sh/wb_rob_tag from that entry.
    - Clear the entry and increment head.
  - Latency is one cycle from the retire edge to store_wb when the address is already valid.
  - One drain per cycle, so back-to-back retired stores produce consecutive store_wb pulses.
  - When no drain occurs, store_wb = 0 and wb_* hold their last values.
  - A committed entry without addr_valid blocks the drain until the AGU update arrives. This is legal, no error.
- Flush
  - Retire in the same cycle is applied first; the retiring store is older than the mispredict.
  - Then tail <= cptr (post-retire), and all uncommitted entries are invalidated.
  - Alloc and AGU updates in the flush cycle are dropped.
  - Committed entries survive and keep draining.
- sq_count = tail − head (wrap-aware), registered.
- No address alignment or range check; data memory owns the address map.

Test Plan:
- Reset low mid-drain (entry committed, store_wb high) → next edge all outputs 0, sq_count = 0, alloc_ready = 1; no further store_wb.
- Alloc tag 3 sw; agu(3, 0x00010020, 0xDEADBEEF); retire 3 → one cycle later store_wb = 1, wb_addr = 0x00010020, wb_data = 0xDEADBEEF, wb_sw_sh = 0, wb_rob_tag = 3, single pulse, sq_count = 0.
- Alloc 8 stores (tags 0–7) → alloc_ready = 0; 9th alloc dropped, retire_err = 1. Retire 0–7 back-to-back with addresses valid → 8 consecutive store_wb pulses in tag order. Pointers wrap and the queue accepts new allocs.
- Alloc tags 4 (sh) then 5; retire 4 before its agu → store_wb stays 0; agu(4, 0x100, 0x0000ABCD) → store_wb next cycle with wb_sw_sh = 1, wb_data = 0x0000ABCD; tag 5 not written.
- Alloc 1, 2, 3; retire 1 and flush in the same cycle → tag 1 drains; entries 2 and 3 are gone, sq_count = 0 after the drain; a later agu for tag 2 is ignored.
- Retire tag 9 when the oldest uncommitted entry is tag 6 → retire_err = 1, no store_wb, queue unchanged.

Source files
------------

// File: rtl/store_commit_queue_if.sv
// Store queue interface: dispatch allocation, AGU resolve, ROB retire/flush,
// and the write port that drives data memory.
interface store_commit_queue_if #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_rob_tag;
    logic             alloc_sh;
    logic             alloc_ready;
    logic             agu_valid;
    logic [TAG_W-1:0] agu_rob_tag;
    logic [31:0]      agu_addr;
    logic [31:0]      agu_data;
    logic             retire_valid;
    logic [TAG_W-1:0] retire_rob_tag;
    logic             flush;
    logic             store_wb;
    logic [31:0]      wb_addr;
    logic [31:0]      wb_data;
    logic             wb_sw_sh;
    logic [TAG_W-1:0] wb_rob_tag;
    logic [CW-1:0]    sq_count;
    logic             retire_err;

    modport master (
        output alloc_valid, alloc_rob_tag, alloc_sh,
        output agu_valid, agu_rob_tag, agu_addr, agu_data,
        output retire_valid, retire_rob_tag, flush,
        input  alloc_ready, store_wb, wb_addr, wb_data, wb_sw_sh, wb_rob_tag,
        input  sq_count, retire_err
    );

    modport slave (
        input  alloc_valid, alloc_rob_tag, alloc_sh,
        input  agu_valid, agu_rob_tag, agu_addr, agu_data,
        input  retire_valid, retire_rob_tag, flush,
        output alloc_ready, store_wb, wb_addr, wb_data, wb_sw_sh, wb_rob_tag,
        output sq_count, retire_err
    );
endinterface

// File: rtl/store_commit_queue.sv
// In-order store queue: holds stores from dispatch to ROB retirement, then
// drains committed, address-resolved stores to data memory one per cycle.
module store_commit_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    store_commit_queue_if.slave  sq_if
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_committed;
    logic [DEPTH-1:0] r_addr_valid;
    logic [DEPTH-1:0] r_sh;
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];

    logic [PW-1:0]    r_head, r_cptr, r_tail, r_count;
    logic             r_store_wb, r_wb_sw_sh, r_err;
    logic [31:0]      r_wb_addr, r_wb_data;
    logic [TAG_W-1:0] r_wb_rob_tag;

    logic [IW-1:0]    w_head_idx, w_cptr_idx, w_tail_idx;
    logic             w_full, w_alloc_ok, w_ret_ok, w_drain, w_err_evt;
    logic [DEPTH-1:0] w_agu_hit, w_flush_kill;
    logic [PW-1:0]    w_head_nxt, w_cptr_nxt, w_tail_nxt;

    assign w_head_idx = r_head[IW-1:0];
    assign w_cptr_idx = r_cptr[IW-1:0];
    assign w_tail_idx = r_tail[IW-1:0];

    // Fullness comes from the registered count, so a same-cycle drain never frees a slot.
    assign w_full     = (r_count == PW'(DEPTH));
    assign w_alloc_ok = sq_if.alloc_valid && !w_full && !sq_if.flush;
    assign w_ret_ok   = sq_if.retire_valid && r_valid[w_cptr_idx] && !r_committed[w_cptr_idx]
                        && (r_tag[w_cptr_idx] == sq_if.retire_rob_tag);
    assign w_drain    = r_valid[w_head_idx] && r_committed[w_head_idx] && r_addr_valid[w_head_idx];
    assign w_err_evt  = (sq_if.retire_valid && !w_ret_ok) || (sq_if.alloc_valid && w_full);

    assign w_head_nxt = r_head + PW'(w_drain);
    assign w_cptr_nxt = r_cptr + PW'(w_ret_ok);
    assign w_tail_nxt = sq_if.flush ? w_cptr_nxt : (r_tail + PW'(w_alloc_ok));

    // A committed store still waiting on its address must stay reachable by the AGU.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_agu_hit    = '0;
        w_flush_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_agu_hit[i]    = sq_if.agu_valid && !sq_if.flush && r_valid[i]
                              && (r_tag[i] == sq_if.agu_rob_tag)
                              && (!r_committed[i] || !r_addr_valid[i]);
            w_flush_kill[i] = sq_if.flush && r_valid[i] && !r_committed[i]
                              && !(w_ret_ok && (IW'(i) == w_cptr_idx));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_valid      <= '0;
            r_committed  <= '0;
            r_addr_valid <= '0;
            r_head       <= '0;
            r_cptr       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_store_wb   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_wb_sw_sh   <= 1'b0;
            r_wb_rob_tag <= '0;
            r_err        <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_cptr     <= w_cptr_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_tail_nxt - w_head_nxt;
            r_err      <= r_err | w_err_evt;
            r_store_wb <= w_drain;
            if (w_drain) begin
                r_wb_addr    <= r_addr[w_head_idx];
                r_wb_data    <= r_data[w_head_idx];
                r_wb_sw_sh   <= r_sh[w_head_idx];
                r_wb_rob_tag <= r_tag[w_head_idx];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_flush_kill[i]) r_valid[i]      <= 1'b0;
                if (w_agu_hit[i])    r_addr_valid[i] <= 1'b1;
            end
            if (w_ret_ok) r_committed[w_cptr_idx] <= 1'b1;
            if (w_drain) begin
                r_valid[w_head_idx]      <= 1'b0;
                r_committed[w_head_idx]  <= 1'b0;
                r_addr_valid[w_head_idx] <= 1'b0;
            end
            if (w_alloc_ok) begin
                r_valid[w_tail_idx]      <= 1'b1;
                r_committed[w_tail_idx]  <= 1'b0;
                r_addr_valid[w_tail_idx] <= 1'b0;
            end
        end
    end

    // NOTE: payload storage has no reset; the flag vectors above gate every read of it.
    always_ff @(posedge clk) begin
        if (w_alloc_ok) begin
            r_tag[w_tail_idx] <= sq_if.alloc_rob_tag;
            r_sh[w_tail_idx]  <= sq_if.alloc_sh;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_agu_hit[i]) begin
                r_addr[i] <= sq_if.agu_addr;
                r_data[i] <= sq_if.agu_data;
            end
        end
    end

    assign sq_if.alloc_ready = !w_full;
    assign sq_if.store_wb    = r_store_wb;
    assign sq_if.wb_addr     = r_wb_addr;
    assign sq_if.wb_data     = r_wb_data;
    assign sq_if.wb_sw_sh    = r_wb_sw_sh;
    assign sq_if.wb_rob_tag  = r_wb_rob_tag;
    assign sq_if.sq_count    = r_count;
    assign sq_if.retire_err  = r_err;
endmodule
